// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush controller: a shift-register scoreboard of in-flight register
// writes drives decode stalls, and a mem-stage redirect becomes a flush.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned NUM_INFLIGHT = 3,
    parameter int unsigned WB_BYPASS    = 1,
    parameter int unsigned FWD_EN       = 0,
    parameter int unsigned REDIRECT_IDX = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_id_valid,
    input  logic [REG_AW-1:0]       i_id_rs1,
    input  logic                    i_id_rs1_used,
    input  logic [REG_AW-1:0]       i_id_rs2,
    input  logic                    i_id_rs2_used,
    input  logic [REG_AW-1:0]       i_id_rd,
    input  logic                    i_id_regwr,
    input  logic                    i_id_load,
    input  logic                    i_redirect,
    output logic                    o_stall,
    output logic                    o_bubble,
    output logic                    o_flush,
    output logic [NUM_INFLIGHT-1:0] o_inflight,
    output logic [CNT_W-1:0]        o_stall_cnt,
    output logic [CNT_W-1:0]        o_flush_cnt
);

    localparam int unsigned LAST = NUM_INFLIGHT - 1;

    logic [NUM_INFLIGHT-1:0] sb_v;
    logic [NUM_INFLIGHT-1:0] sb_ld;
    logic [REG_AW-1:0]       sb_rd [NUM_INFLIGHT];

    logic [NUM_INFLIGHT-1:0] nxt_v;
    logic [NUM_INFLIGHT-1:0] nxt_ld;
    logic [REG_AW-1:0]       nxt_rd [NUM_INFLIGHT];

    logic [NUM_INFLIGHT-1:0] visible;
    logic [NUM_INFLIGHT-1:0] hit_rs1;
    logic [NUM_INFLIGHT-1:0] hit_rs2;
    logic                    hazard;
    logic                    issue;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        flush_cnt;

    // A slot is visible to decode unless write-first regfile covers it, or
    // forwarding covers everything except a load still in execute.
    always_comb begin
        visible = '0;
        hit_rs1 = '0;
        hit_rs2 = '0;
        for (int unsigned i = 0; i < NUM_INFLIGHT; i++) begin
            visible[i] = sb_v[i];
            if (WB_BYPASS != 0 && i == LAST)
                visible[i] = 1'b0;
            if (FWD_EN != 0 && (i != 0 || !sb_ld[i]))
                visible[i] = 1'b0;
            hit_rs1[i] = visible[i] && (sb_rd[i] == i_id_rs1) && (i_id_rs1 != '0);
            hit_rs2[i] = visible[i] && (sb_rd[i] == i_id_rs2) && (i_id_rs2 != '0);
        end
    end

    assign hazard   = (i_id_rs1_used & (|hit_rs1)) | (i_id_rs2_used & (|hit_rs2));
    assign o_flush  = reset & i_redirect;
    assign o_stall  = reset & i_id_valid & hazard & ~i_redirect;
    assign o_bubble = o_stall | o_flush;

    assign issue = i_id_valid & i_id_regwr & (i_id_rd != '0) & ~o_stall & ~i_redirect;

    // Shift by one; on redirect the slots younger than the redirecting
    // instruction are dropped as they move up.
    always_comb begin
        nxt_v     = '0;
        nxt_ld    = '0;
        nxt_v[0]  = issue;
        nxt_ld[0] = issue & i_id_load;
        nxt_rd[0] = issue ? i_id_rd : '0;
        for (int unsigned i = 1; i < NUM_INFLIGHT; i++) begin
            nxt_v[i]  = sb_v[i-1] & ~(i_redirect & (i <= REDIRECT_IDX));
            nxt_ld[i] = sb_ld[i-1];
            nxt_rd[i] = sb_rd[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_v  <= '0;
            sb_ld <= '0;
            for (int unsigned i = 0; i < NUM_INFLIGHT; i++)
                sb_rd[i] <= '0;
        end else begin
            sb_v  <= nxt_v;
            sb_ld <= nxt_ld;
            for (int unsigned i = 0; i < NUM_INFLIGHT; i++)
                sb_rd[i] <= nxt_rd[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (o_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (o_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign o_inflight  = sb_v;
    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;

endmodule
